// File: rtl/clk_meas_pkg.sv
// clk_meas_pkg
// Shared definitions for the clock period meter: the measurement FSM state
// type and the default counter width.
package clk_meas_pkg;

    localparam int DEFAULT_WIDTH = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,   // waiting for the first rising edge of sig_in
        MEAS = 2'd1,   // counting period and high time
        SAT  = 2'd2    // period counter saturated, timeout asserted
    } meas_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det
// Two-flop synchronizer for an asynchronous input followed by a registered
// rise/fall edge detector. rise/fall are one-cycle pulses that line up with
// the cycle in which the synchronized level has just changed.
//
// Ports:
//   clk     system clock (rising edge)
//   rst     asynchronous active-high reset
//   sig_in  asynchronous input
//   rise    one-cycle pulse, synchronized sig_in went 0->1
//   fall    one-cycle pulse, synchronized sig_in went 1->0
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic sync_1;
    logic sync_2;
    logic sync_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
        end else begin
            sync_1    <= sig_in;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
            rise      <= sync_2 & ~sync_prev;
            fall      <= ~sync_2 & sync_prev;
        end
    end

endmodule

// File: rtl/clk_period_meter.sv
// clk_period_meter
// Measures the period and high time of a slow, asynchronous clock (sig_in)
// in units of clk cycles. Each rising edge of sig_in after the first
// publishes the counts of the previous period and pulses meas_valid.
// If no rising edge arrives within 2**WIDTH-1 cycles the counters stop and
// timeout is raised until the next rising edge.
//
// Optional feature (macro CLK_PERIOD_METER_CHECK_EN): every published period
// is compared against EXPECT_N +/- TOL; a miss sets the sticky mismatch flag.
// With the macro undefined, mismatch is tied low.
//
// Parameters:
//   WIDTH     counter / output width
//   EXPECT_N  expected period in clk cycles (check feature only)
//   TOL       allowed absolute deviation from EXPECT_N (check feature only)
//
// Ports:
//   clk         system clock (rising edge)
//   rst         asynchronous active-high reset
//   sig_in      clock under measurement, asynchronous to clk
//   period_out  clk cycles between the last two rising edges of sig_in
//   high_out    clk cycles sig_in was high within that period
//   meas_valid  one-cycle pulse when period_out/high_out update
//   timeout     level, no rising edge within 2**WIDTH-1 cycles
//   mismatch    sticky, a published period was out of range
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int          WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned EXPECT_N = 24'd11_999_999,
    parameter int unsigned TOL      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [WIDTH-1:0] period_out,
    output logic [WIDTH-1:0] high_out,
    output logic             meas_valid,
    output logic             timeout,
    output logic             mismatch
);

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    logic rise;
    logic fall;

    sync_edge_det u_sync_edge_det (
        .clk    (clk),
        .rst    (rst),
        .sig_in (sig_in),
        .rise   (rise),
        .fall   (fall)
    );

    // Synchronized level rebuilt from the edge pulses, aligned with them.
    logic level_q;
    logic level_now;
    assign level_now = rise ? 1'b1 : (fall ? 1'b0 : level_q);

    meas_state_t      state;
    logic [WIDTH-1:0] period_cnt;
    logic [WIDTH-1:0] high_cnt;

`ifdef CLK_PERIOD_METER_CHECK_EN
    localparam logic [63:0] CHK_LO = (EXPECT_N > TOL) ? 64'(EXPECT_N - TOL) : 64'd0;
    localparam logic [63:0] CHK_HI = 64'(EXPECT_N) + 64'(TOL);

    logic out_of_range;
    logic mismatch_q;
    assign out_of_range = (64'(period_cnt) < CHK_LO) || (64'(period_cnt) > CHK_HI);
    assign mismatch     = mismatch_q;
`else
    assign mismatch = 1'b0;
`endif

    // The cycle of a rise is counted as the first cycle of the new period,
    // so period_cnt holds the true elapsed count and is published as-is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            period_cnt <= '0;
            high_cnt   <= '0;
            period_out <= '0;
            high_out   <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            level_q    <= 1'b0;
`ifdef CLK_PERIOD_METER_CHECK_EN
            mismatch_q <= 1'b0;
`endif
        end else begin
            meas_valid <= 1'b0;
            level_q    <= level_now;
            case (state)
                IDLE: begin
                    if (rise) begin
                        state      <= MEAS;
                        period_cnt <= WIDTH'(1);
                        high_cnt   <= WIDTH'(1);
                    end
                end
                MEAS: begin
                    if (rise) begin
                        // A rise on the saturating cycle is a restart, not a result.
                        if (period_cnt != CNT_MAX) begin
                            period_out <= period_cnt;
                            high_out   <= high_cnt;
                            meas_valid <= 1'b1;
`ifdef CLK_PERIOD_METER_CHECK_EN
                            if (out_of_range) begin
                                mismatch_q <= 1'b1;
                            end
`endif
                        end
                        period_cnt <= WIDTH'(1);
                        high_cnt   <= WIDTH'(1);
                    end else if (period_cnt == CNT_MAX) begin
                        state   <= SAT;
                        timeout <= 1'b1;
                    end else begin
                        period_cnt <= period_cnt + WIDTH'(1);
                        high_cnt   <= high_cnt + WIDTH'(level_now);
                    end
                end
                SAT: begin
                    if (rise) begin
                        state      <= MEAS;
                        timeout    <= 1'b0;
                        period_cnt <= WIDTH'(1);
                        high_cnt   <= WIDTH'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
